// File: rtl/regfile_writeback_queue.sv
// Register file writeback queue: merges ALU and mult/div writeback requests
// into a small in-order queue, drains one entry per cycle onto the register
// file write port, and forwards queued values to the two read ports.
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             alu_valid,
    input  logic [4:0]       alu_reg,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    input  logic             md_valid,
    input  logic [4:0]       md_reg,
    input  logic [31:0]      md_data,
    output logic             md_ready,
    output logic             ctrl_writeEnable,
    output logic [4:0]       ctrl_writeReg,
    output logic [31:0]      data_writeReg,
    input  logic [4:0]       ctrl_readRegA,
    input  logic [4:0]       ctrl_readRegB,
    input  logic [31:0]      rf_dataA,
    input  logic [31:0]      rf_dataB,
    output logic [31:0]      fwd_dataA,
    output logic [31:0]      fwd_dataB,
    output logic [CNT_W-1:0] pending_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [4:0]       entry_reg_q  [DEPTH];
    logic [31:0]      entry_data_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0] free_cnt;
    logic [CNT_W-1:0] md_need;
    logic             alu_enq;
    logic             md_enq;
    logic             pop;
    logic [PTR_W-1:0] md_slot;

    // Handshake, enqueue/pop decisions and next pointer/count values.
    // Readiness looks only at current occupancy; a pop in the same cycle
    // does not free a slot for this cycle's requests.
    always_comb begin
        free_cnt  = DEPTH_C - count_q;
        md_need   = (alu_valid && alu_reg != 5'd0) ? CNT_W'(2) : CNT_W'(1);
        alu_ready = (free_cnt >= CNT_W'(1));
        md_ready  = (free_cnt >= md_need);
        alu_enq   = alu_valid && alu_ready && (alu_reg != 5'd0);
        md_enq    = md_valid && md_ready && (md_reg != 5'd0);
        pop       = (count_q != '0);
        md_slot   = wr_ptr_q + (alu_enq ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d  = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));
        wr_ptr_d  = md_slot + (md_enq ? PTR_W'(1) : PTR_W'(0));
        count_d   = count_q + CNT_W'(alu_enq) + CNT_W'(md_enq) - CNT_W'(pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; ALU lands first (older), mult/div in the following slot.
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            if (alu_enq) begin
                entry_reg_q[wr_ptr_q]  <= alu_reg;
                entry_data_q[wr_ptr_q] <= alu_data;
            end
            if (md_enq) begin
                entry_reg_q[md_slot]  <= md_reg;
                entry_data_q[md_slot] <= md_data;
            end
        end
    end

    // Write port driven straight from the queue head; zeros when empty.
    always_comb begin
        ctrl_writeEnable = pop;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        if (pop) begin
            ctrl_writeReg = entry_reg_q[rd_ptr_q];
            data_writeReg = entry_data_q[rd_ptr_q];
        end
    end

    // Forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd_dataA = rf_dataA;
        fwd_dataB = rf_dataB;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (ctrl_readRegA != 5'd0 && entry_reg_q[idx] == ctrl_readRegA)
                    fwd_dataA = entry_data_q[idx];
                if (ctrl_readRegB != 5'd0 && entry_reg_q[idx] == ctrl_readRegB)
                    fwd_dataB = entry_data_q[idx];
            end
        end
    end

    assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios plus
// randomized traffic, all compared against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clock = 1'b0;
    logic             ctrl_reset;
    logic             alu_valid, md_valid;
    logic [4:0]       alu_reg, md_reg;
    logic [31:0]      alu_data, md_data;
    logic             alu_ready, md_ready;
    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [31:0]      data_writeReg;
    logic [4:0]       ctrl_readRegA, ctrl_readRegB;
    logic [31:0]      rf_dataA, rf_dataB;
    logic [31:0]      fwd_dataA, fwd_dataB;
    logic [CNT_W-1:0] pending_count;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t model_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   alu_stall = 0;
    bit   md_stall  = 0;

    always #5 clock = ~clock;

    regfile_writeback_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .alu_valid        (alu_valid),
        .alu_reg          (alu_reg),
        .alu_data         (alu_data),
        .alu_ready        (alu_ready),
        .md_valid         (md_valid),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .rf_dataA         (rf_dataA),
        .rf_dataB         (rf_dataB),
        .fwd_dataA        (fwd_dataA),
        .fwd_dataB        (fwd_dataB),
        .pending_count    (pending_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] ra, input logic [31:0] rf);
        logic [31:0] v;
        v = rf;
        if (ra != 5'd0)
            foreach (model_q[i])
                if (model_q[i].r == ra) v = model_q[i].d;
        return v;
    endfunction

    // Compare every output against the model, then advance the model across
    // the next rising edge. Called just after a falling edge with inputs set.
    task automatic step();
        int free;
        bit exp_ar, exp_mr;
        ent_t head;
        #1;
        free   = DEPTH - model_q.size();
        exp_ar = (free >= 1);
        exp_mr = (free >= 1 + ((alu_valid && alu_reg != 5'd0) ? 1 : 0));
        head   = (model_q.size() != 0) ? model_q[0] : '0;
        check_eq("alu_ready", 32'(alu_ready), 32'(exp_ar));
        check_eq("md_ready", 32'(md_ready), 32'(exp_mr));
        check_eq("pending_count", 32'(pending_count), 32'(model_q.size()));
        check_eq("writeEnable", 32'(ctrl_writeEnable), 32'(model_q.size() != 0));
        check_eq("writeReg", 32'(ctrl_writeReg), 32'(head.r));
        check_eq("writeData", data_writeReg, head.d);
        check_eq("fwd_dataA", fwd_dataA, model_fwd(ctrl_readRegA, rf_dataA));
        check_eq("fwd_dataB", fwd_dataB, model_fwd(ctrl_readRegB, rf_dataB));
        alu_stall = alu_valid && !exp_ar;
        md_stall  = md_valid && !exp_mr;
        if (ctrl_reset) begin
            model_q.delete();
        end else begin
            if (model_q.size() != 0) void'(model_q.pop_front());
            if (alu_valid && exp_ar && alu_reg != 5'd0) model_q.push_back('{alu_reg, alu_data});
            if (md_valid && exp_mr && md_reg != 5'd0) model_q.push_back('{md_reg, md_data});
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        md_valid  = 0; md_reg  = 0; md_data  = 0;
    endtask

    initial begin
        ctrl_reset = 1; idle_inputs();
        ctrl_readRegA = 0; ctrl_readRegB = 0;
        rf_dataA = 32'hA5A5_0001; rf_dataB = 32'h5A5A_0002;
        repeat (2) @(posedge clock);
        @(negedge clock);
        ctrl_reset = 0;
        model_q.delete();

        // Single ALU write: issued next cycle, then drained.
        alu_valid = 1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        check_eq("t1_we", 32'(ctrl_writeEnable), 32'd1);
        check_eq("t1_reg", 32'(ctrl_writeReg), 32'd5);
        check_eq("t1_data", data_writeReg, 32'hDEADBEEF);
        check_eq("t1_cnt", 32'(pending_count), 32'd1);
        step();
        check_eq("t1_we_after", 32'(ctrl_writeEnable), 32'd0);
        check_eq("t1_cnt_after", 32'(pending_count), 32'd0);

        // Both sources every cycle until back-pressure, then drain.
        for (int k = 0; k < 6; k++) begin
            if (!alu_stall) begin alu_valid = 1; alu_reg = 5'(2 * k + 1); alu_data = 32'h100 + k; end
            if (!md_stall)  begin md_valid = 1;  md_reg  = 5'(2 * k + 2); md_data  = 32'h200 + k; end
            step();
        end
        idle_inputs();
        repeat (5) step();

        // r0 request: handshake completes, nothing stored.
        alu_valid = 1; alu_reg = 0; alu_data = 32'h12345678; ctrl_readRegA = 0;
        step();
        idle_inputs();
        check_eq("t3_cnt", 32'(pending_count), 32'd0);
        check_eq("t3_fwdA", fwd_dataA, rf_dataA);
        step();

        // Same register from both sources: mult/div value is younger.
        alu_valid = 1; alu_reg = 5'd7; alu_data = 32'h1111;
        md_valid  = 1; md_reg  = 5'd7; md_data  = 32'h2222;
        ctrl_readRegA = 5'd7; rf_dataA = 0;
        step();
        idle_inputs();
        check_eq("t4_fwd1", fwd_dataA, 32'h2222);
        check_eq("t4_wr1", data_writeReg, 32'h1111);
        step();
        check_eq("t4_fwd2", fwd_dataA, 32'h2222);
        check_eq("t4_wr2", data_writeReg, 32'h2222);
        rf_dataA = 32'h0000_ABCD;
        step();
        check_eq("t4_fwd3", fwd_dataA, 32'h0000_ABCD);

        // Reset with entries queued.
        alu_valid = 1; alu_reg = 5'd3; alu_data = 32'h33;
        md_valid  = 1; md_reg  = 5'd4; md_data  = 32'h44;
        ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd4;
        step(); step();
        idle_inputs();
        ctrl_reset = 1;
        step();
        ctrl_reset = 0;
        check_eq("t5_cnt", 32'(pending_count), 32'd0);
        check_eq("t5_we", 32'(ctrl_writeEnable), 32'd0);
        check_eq("t5_fwdA", fwd_dataA, rf_dataA);
        check_eq("t5_fwdB", fwd_dataB, rf_dataB);
        check_eq("t5_ardy", 32'(alu_ready), 32'd1);
        check_eq("t5_mrdy", 32'(md_ready), 32'd1);
        step();

        // Randomized traffic with sources holding while stalled.
        alu_stall = 0; md_stall = 0;
        for (int n = 0; n < 600; n++) begin
            ctrl_reset = ($urandom_range(0, 79) == 0);
            if (!alu_stall) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_reg   = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!md_stall) begin
                md_valid = ($urandom_range(0, 2) != 0);
                md_reg   = 5'($urandom_range(0, 7));
                md_data  = $urandom;
            end
            ctrl_readRegA = 5'($urandom_range(0, 7));
            ctrl_readRegB = 5'($urandom_range(0, 7));
            rf_dataA = $urandom;
            rf_dataB = $urandom;
            step();
        end
        ctrl_reset = 0;
        idle_inputs();
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
